// File: rtl/alu_pkg.sv
// Shared decode constants, the ALU operation enum and funct3-to-op helpers for the RV32I ALU.
// The RV32M_EN macro enables the multiply/divide group; see alu.sv and alu_decode.sv.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS2,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  // Integer table shared by OP and OP-IMM; alt picks SUB/SRA.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e muldiv_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_MUL:    op = ALU_MUL;
      F3_MULH:   op = ALU_MULH;
      F3_MULHSU: op = ALU_MULHSU;
      F3_MULHU:  op = ALU_MULHU;
      F3_DIV:    op = ALU_DIV;
      F3_DIVU:   op = ALU_DIVU;
      F3_REM:    op = ALU_REM;
      default:   op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: maps opcode/funct3/funct7 onto an alu_op_e.
// RV32M_EN adds the funct7=0000001 multiply/divide group on OP.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_op_e     op_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign alt    = instr_i[30];

  // Register specifiers never influence the operation.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    op_o = ALU_ZERO;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE, F7_ALT: op_o = base_op(funct3, alt);
          F7_MULDIV: begin
`ifdef RV32M_EN
            op_o = muldiv_op(funct3);
`else
            op_o = ALU_ZERO;
`endif
          end
          default: op_o = ALU_ZERO;
        endcase
      end
      // ADDI has no subtract form, so alt only matters for the shift.
      OPC_OPIMM: op_o = (funct3 == F3_ADD) ? ALU_ADD : base_op(funct3, alt);
      OPC_LOAD, OPC_STORE, OPC_JALR: op_o = ALU_ADD;
      OPC_LUI: op_o = ALU_PASS2;
      default: op_o = ALU_ZERO;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU with a one-cycle registered result.
// Define RV32M_EN to add the single-cycle RV32M multiply/divide operations.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] res
);

  alu_op_e         op;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] sra_val;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] res_d;
  logic [XLEN-1:0] res_q;

  alu_decode u_decode (
    .instr_i (instr),
    .op_o    (op)
  );

  assign shamt   = op2[4:0];
  assign sum     = op1 + op2;
  assign diff    = op1 - op2;
  assign sra_val = $unsigned($signed(op1) >>> shamt);
  assign lt_s    = $signed(op1) < $signed(op2);
  assign lt_u    = op1 < op2;

`ifdef RV32M_EN
  logic [2*XLEN-1:0] prod_ss;
  logic [2*XLEN-1:0] prod_su;
  logic [2*XLEN-1:0] prod_uu;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   quot_u;
  logic [XLEN-1:0]   rem_u;

  // Sign/zero-extending to 2*XLEN lets one truncated multiply serve every MULH variant.
  assign prod_ss = {{XLEN{op1[XLEN-1]}}, op1} * {{XLEN{op2[XLEN-1]}}, op2};
  assign prod_su = {{XLEN{op1[XLEN-1]}}, op1} * {{XLEN{1'b0}}, op2};
  assign prod_uu = {{XLEN{1'b0}}, op1} * {{XLEN{1'b0}}, op2};

  assign div_zero = (op2 == '0);
  assign div_ovf  = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign quot_s   = $unsigned($signed(op1) / $signed(op2));
  assign rem_s    = $unsigned($signed(op1) % $signed(op2));
  assign quot_u   = op1 / op2;
  assign rem_u    = op1 % op2;
`endif

  always_comb begin
    res_d = '0;
    case (op)
      ALU_ADD:   res_d = sum;
      ALU_SUB:   res_d = diff;
      ALU_SLL:   res_d = op1 << shamt;
      ALU_SLT:   res_d = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  res_d = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:   res_d = op1 ^ op2;
      ALU_SRL:   res_d = op1 >> shamt;
      ALU_SRA:   res_d = sra_val;
      ALU_OR:    res_d = op1 | op2;
      ALU_AND:   res_d = op1 & op2;
      ALU_PASS2: res_d = op2;
`ifdef RV32M_EN
      ALU_MUL:    res_d = prod_ss[XLEN-1:0];
      ALU_MULH:   res_d = prod_ss[2*XLEN-1:XLEN];
      ALU_MULHSU: res_d = prod_su[2*XLEN-1:XLEN];
      ALU_MULHU:  res_d = prod_uu[2*XLEN-1:XLEN];
      ALU_DIV:    res_d = div_zero ? '1 : (div_ovf ? op1 : quot_s);
      ALU_DIVU:   res_d = div_zero ? '1 : quot_u;
      ALU_REM:    res_d = div_zero ? op1 : (div_ovf ? '0 : rem_s);
      ALU_REMU:   res_d = div_zero ? op1 : rem_u;
`endif
      default:   res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: reset, RV32I table, boundaries, back-to-back latency.
// Adds RV32M vectors when RV32M_EN is defined, otherwise checks funct7=0000001 gives zero.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] instr;
  logic [31:0] res;

  int          total;
  int          bad;
  logic [31:0] prev_exp;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .op1   (op1),
    .op2   (op2),
    .instr (instr),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Before the edge res must still show the previous result; after it, the new one.
  task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    instr = i;
    op1   = a;
    op2   = b;
    #1;
    chk(res, prev_exp, {tag, "_hold"});
    @(posedge clk);
    #1;
    chk(res, exp, tag);
    $display("step %s instr=%h op1=%h op2=%h res=%h", tag, i, a, b, res);
    prev_exp = exp;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_exp = 32'h0;

    reset = 1'b1;
    instr = 32'h002081B3;
    op1   = 32'h00000005;
    op2   = 32'h00000003;
    @(posedge clk);
    #1;
    chk(res, 32'h0, "reset_c1");
    @(posedge clk);
    #1;
    chk(res, 32'h0, "reset_c2");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk(res, 32'h00000008, "post_reset_add");
    prev_exp = 32'h00000008;

    // Continuous stream: a new instruction every cycle.
    step(32'h002081B3, 32'h00000005, 32'h00000003, 32'h00000008, "add");
    step(32'h402081B3, 32'h00000005, 32'h00000003, 32'h00000002, "sub");
    step(32'h402081B3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub_wrap");
    step(32'h0020A1B3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt");
    step(32'h0020B1B3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu");
    step(32'h4020D1B3, 32'h80000000, 32'h00000024, 32'hF8000000, "sra");
    step(32'h4040D193, 32'h80000000, 32'h00000404, 32'hF8000000, "srai");
    step(32'hFFF08193, 32'h00000010, 32'hFFFFFFFF, 32'h0000000F, "addi");
    step(32'h00000003, 32'h00001000, 32'hFFFFFFFC, 32'h00000FFC, "load");
    step(32'h0000007F, 32'h00000005, 32'h00000003, 32'h00000000, "unknown_opc");
    step(32'h002091B3, 32'h00000001, 32'h00000021, 32'h00000002, "sll");
    step(32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    step(32'h0020D1B3, 32'h80000000, 32'h00000004, 32'h08000000, "srl");
    step(32'h0020E1B3, 32'hF0000000, 32'h0000000F, 32'hF000000F, "or");
    step(32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    step(32'h00000023, 32'h00000100, 32'h00000008, 32'h00000108, "store");
    step(32'h00000067, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, "jalr_wrap");
    step(32'h00000037, 32'h00001234, 32'hABCDE000, 32'hABCDE000, "lui");
    step(32'h082081B3, 32'h00000005, 32'h00000003, 32'h00000000, "bad_funct7");
    step(32'h40008193, 32'h00000010, 32'h00000005, 32'h00000015, "addi_alt_ignored");
    step(32'h0000A193, 32'h80000000, 32'h00000000, 32'h00000001, "slti");
    step(32'h0000B193, 32'h80000000, 32'h00000000, 32'h00000000, "sltiu");
    step(32'h002091B3, 32'h00000001, 32'hFFFFFFE0, 32'h00000001, "sll_shamt0");
    step(32'h4020D1B3, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, "sra_pos31");
    step(32'h00208FB3, 32'h00000001, 32'h00000002, 32'h00000003, "add_rd31");

`ifdef RV32M_EN
    step(32'h0200C1B3, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, "div_by0");
    step(32'h0200B1B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    step(32'h020081B3, 32'h00000003, 32'h00000005, 32'h0000000F, "mul");
    step(32'h0200C1B3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    step(32'h0200E1B3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
    step(32'h0200F1B3, 32'h00001234, 32'h00000000, 32'h00001234, "remu_by0");
    step(32'h0200C1B3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_neg");
    step(32'h020091B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh");
`else
    step(32'h020081B3, 32'h00000005, 32'h00000003, 32'h00000000, "muldiv_disabled");
    step(32'h0200C1B3, 32'h00001234, 32'h00000000, 32'h00000000, "div_disabled");
`endif

    // Reset wins over a live operation.
    instr = 32'h002081B3;
    op1   = 32'h00000005;
    op2   = 32'h00000003;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk(res, 32'h0, "reset_dominates");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- RV32I integer execute-stage ALU with a registered result.
- Decodes the full 32-bit instruction word (opcode, funct3, funct7) and operates on op1 (rs1 value) and op2 (rs2 value, or the already sign-extended immediate).
- Sits between the register-read/immediate-generation logic and writeback/memory address logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op1  in  32  rs1 operand
- op2  in  32  rs2 operand, or sign-extended immediate for I/S-type instructions
- instr  in  32  raw instruction word
- res  out  32  registered result

Behaviour:
- Reset: on a rising clk edge with reset=1, res <= 0. Reset dominates any concurrent operation.
- Latency: inputs are sampled at rising edge N; res holds the result from edge N until edge N+1.
  - No handshake. A new operation is accepted every cycle.
- Decode fields: opcode=instr[6:0], funct3=instr[14:12], alt=instr[30].
- OP (0110011), funct7 = 0000000 or 0100000:
  - 000: ADD when alt=0, SUB when alt=1.
  - 001: SLL. 010: SLT (signed). 011: SLTU.
  - 100: XOR. 101: SRL when alt=0, SRA when alt=1.
  - 110: OR. 111: AND.
- OP-IMM (0010011): same table using op2.
  - funct3=000 is always ADDI; alt is ignored.
  - SRLI/SRAI are selected by alt.
- Shift amount is always op2[4:0]; upper bits of op2 are ignored.
- SLT/SLTU produce 32'h1 or 32'h0.
- Add/sub wrap modulo 2^32; no overflow flag.
- LOAD (0000011), STORE (0100011), JALR (1100111): res = op1 + op2 (address).
- LUI (0110111): res = op2; the immediate is supplied pre-shifted on op2.
- Any other opcode, or an unlisted funct7 value on OP: res = 0.
- Only instr[6:0], [14:12] and [31:25] are decoded; rd/rs fields are ignored.

Optional Feature:
- Macro RV32M_EN.
- Defined: OP with funct7=0000001 executes RV32M:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Divide by zero: DIV/DIVU give 32'hFFFFFFFF; REM/REMU give op1.
  - Signed overflow (0x80000000 / -1): DIV gives 0x80000000; REM gives 0.
  - Same one-cycle latency as all other operations.
- Undefined: funct7=0000001 yields res = 0.

Decomposition:
- Package alu_pkg holds:
  - opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI);
  - funct3 constants (F3_ADD … F3_AND, plus the M-extension funct3 set);
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV);
  - an ALU-operation enum.
- One natural sub-module: alu_decode. It maps instr to the op enum combinationally.
- alu itself holds the datapath and the result register.

Test Plan:
- Reset: assert reset for 2 cycles with non-zero inputs -> res = 0; deassert -> next edge shows the computed result.
- ADD/SUB:
  - instr=002081B3, op1=00000005, op2=00000003 -> res=00000008, one cycle later.
  - instr=402081B3, same operands -> res=00000002.
  - instr=402081B3, op1=0, op2=1 -> res=FFFFFFFF.
- Compare:
  - SLT instr=0020A1B3, op1=FFFFFFFF, op2=00000001 -> 00000001.
  - SLTU instr=0020B1B3, same operands -> 00000000.
- Shifts:
  - SRA instr=4020D1B3, op1=80000000, op2=00000024 (shamt 4) -> F8000000.
  - SRAI instr=4040D193, op1=80000000, op2=00000404 -> F8000000.
- Immediate/address:
  - ADDI instr=FFF08193, op1=00000010, op2=FFFFFFFF -> 0000000F.
  - LOAD opcode, op1=00001000, op2=FFFFFFFC -> 00000FFC.
  - Unknown opcode 7F -> 00000000.
- Back-to-back: a different instruction every cycle for 20 cycles -> each result appears exactly one edge after its inputs.
  - With RV32M_EN: DIV by zero -> FFFFFFFF; MULHU FFFFFFFF×FFFFFFFF -> FFFFFFFE.
